// File: rtl/frame_loader.sv
// frame_loader: receives a 16x8 monochrome bitmap over a slow 3-wire serial link into a
// shadow buffer, and swaps it into the display buffer only at the scan driver's frame
// boundary, so the panel never shows a torn frame.
module frame_loader #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NCOLS       = 16,
    parameter int unsigned NROWS       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_clk_in,
    input  logic       ser_data_in,
    input  logic       ser_load_n_in,
    input  logic       frame_sync_in,
    input  logic [3:0] rd_col_in,
    input  logic [2:0] rd_row_in,
    output logic       rd_pixel_out,
    output logic       frame_pending_out,
    output logic       frame_err_out
);

    localparam int unsigned NBITS = NCOLS * NROWS;
    localparam int unsigned IDXW  = $clog2(NBITS);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    // Synchronizers; the newest sample enters at bit 0, the settled one leaves at the top.
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic                   r_clk_hist;
    logic                   r_load_hist;

    state_e                 r_state;
    state_e                 w_state_next;

    // Buffers are flat, indexed by {col, row}.
    logic [NBITS-1:0]       r_shadow;
    logic [NBITS-1:0]       r_display;
    logic [7:0]             r_bit_cnt;
    logic                   r_overrun;
    logic                   r_pending;
    logic                   r_err;

    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_load_s;
    logic                   w_clk_rise;
    logic                   w_load_fall;
    logic                   w_load_rise;
    logic                   w_cnt_full;
    logic                   w_swap;
    logic [IDXW-1:0]        w_wr_idx;

    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s    = r_data_sync[SYNC_STAGES-1];
    assign w_load_s    = r_load_sync[SYNC_STAGES-1];
    assign w_clk_rise  = w_clk_s & ~r_clk_hist;
    assign w_load_fall = ~w_load_s & r_load_hist;
    assign w_load_rise = w_load_s & ~r_load_hist;
    assign w_cnt_full  = (r_bit_cnt == 8'(NBITS));
    // Bit n lands at col 15 - n[6:3], row 7 - n[2:0], i.e. flat index 127 - n.
    assign w_wr_idx    = IDXW'(NBITS - 1) - r_bit_cnt[IDXW-1:0];
    // Uses the registered pending flag, so a frame completing this cycle waits for the next sync.
    assign w_swap      = frame_sync_in & r_pending;

    assign rd_pixel_out      = r_display[{rd_col_in, rd_row_in}];
    assign frame_pending_out = r_pending;
    assign frame_err_out     = r_err;

    // Input synchronizers and edge-detect history, reset to the idle line levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync  <= '0;
            r_data_sync <= '0;
            r_load_sync <= '1;
            r_clk_hist  <= 1'b0;
            r_load_hist <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ser_clk_in};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ser_data_in};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], ser_load_n_in};
            r_clk_hist  <= w_clk_s;
            r_load_hist <= w_load_s;
        end
    end

    // Load FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Load FSM next state: a load window opens on load_n fall and closes on its rise.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_load_fall) w_state_next = StShift;
            StShift: if (w_load_rise) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Shift datapath, frame status flags and the shadow-to-display swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow  <= '0;
            r_display <= '0;
            r_bit_cnt <= '0;
            r_overrun <= 1'b0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_swap) begin
                r_display <= r_shadow;
                r_pending <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_load_fall) begin
                        r_bit_cnt <= '0;
                        r_overrun <= 1'b0;
                        r_pending <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                StShift: begin
                    // The window close wins over a ser_clk edge seen in the same cycle.
                    if (w_load_rise) begin
                        if (w_cnt_full && !r_overrun) begin
                            r_pending <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (w_clk_rise) begin
                        if (!w_cnt_full) begin
                            r_shadow[w_wr_idx] <= w_data_s;
                            r_bit_cnt          <= r_bit_cnt + 8'd1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: serial frame loads, swap timing, error cases, reset abort.
module tb_frame_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_clk_in;
    logic       ser_data_in;
    logic       ser_load_n_in;
    logic       frame_sync_in;
    logic [3:0] rd_col_in;
    logic [2:0] rd_row_in;
    logic       rd_pixel_out;
    logic       frame_pending_out;
    logic       frame_err_out;

    typedef struct {
        logic [3:0] col;
        logic [2:0] row;
        logic       exp;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    logic sb_q[$];
    vec_t vecs[14];

    logic [127:0] frame_a;
    logic [127:0] frame_b;
    logic [127:0] frame_c;
    logic [127:0] frame_d;
    logic [127:0] frame_f;

    frame_loader #(
        .SYNC_STAGES(2),
        .NCOLS(16),
        .NROWS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ser_clk_in(ser_clk_in),
        .ser_data_in(ser_data_in),
        .ser_load_n_in(ser_load_n_in),
        .frame_sync_in(frame_sync_in),
        .rd_col_in(rd_col_in),
        .rd_row_in(rd_row_in),
        .rd_pixel_out(rd_pixel_out),
        .frame_pending_out(frame_pending_out),
        .frame_err_out(frame_err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Expected pixel goes into the scoreboard with the address; popped once the read settles.
    task automatic rd_check(input string name, input int col, input int row, input logic exp);
        logic e;
        rd_col_in = 4'(col);
        rd_row_in = 3'(row);
        sb_q.push_back(exp);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got empty scoreboard required one entry", name);
        end else begin
            e = sb_q.pop_front();
            check_bit($sformatf("%s rd(%0d,%0d)", name, col, row), rd_pixel_out, e);
        end
    endtask

    task automatic sweep(input string name, input logic [127:0] f);
        for (int c = 0; c < 16; c++) begin
            for (int r = 0; r < 8; r++) begin
                rd_check(name, c, r, f[c*8+r]);
            end
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        ser_load_n_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ser_data_in = b;
        repeat (4) @(negedge clk);
        ser_clk_in = 1'b1;
        repeat (4) @(negedge clk);
        ser_clk_in = 1'b0;
    endtask

    // Stream bit i carries flat index 127-i, so the first bit is col 15 row 7.
    task automatic send_bits(input logic [127:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < 128) send_bit(f[127-i]);
            else         send_bit(1'b1);
        end
    endtask

    task automatic end_load();
        repeat (4) @(negedge clk);
        ser_load_n_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Raise load_n so pending sets on exactly the edge where frame_sync is high.
    task automatic end_load_aligned();
        repeat (4) @(negedge clk);
        ser_load_n_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frame_sync_in = 1'b1;
        @(negedge clk);
        frame_sync_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_sync();
        @(negedge clk);
        frame_sync_in = 1'b1;
        @(negedge clk);
        frame_sync_in = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        frame_a = 128'd0;
        frame_a[127] = 1'b1;
        frame_b = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        frame_c = ~frame_b;
        frame_d = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        frame_f = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;

        // Pixels of frame_b, derived by hand from its hex bytes (col c = byte c).
        vecs[0]  = '{4'd15, 3'd0, 1'b1};
        vecs[1]  = '{4'd15, 3'd1, 1'b0};
        vecs[2]  = '{4'd15, 3'd7, 1'b0};
        vecs[3]  = '{4'd14, 3'd0, 1'b1};
        vecs[4]  = '{4'd14, 3'd1, 1'b1};
        vecs[5]  = '{4'd14, 3'd2, 1'b0};
        vecs[6]  = '{4'd14, 3'd5, 1'b1};
        vecs[7]  = '{4'd8,  3'd4, 1'b0};
        vecs[8]  = '{4'd8,  3'd3, 1'b1};
        vecs[9]  = '{4'd7,  3'd0, 1'b0};
        vecs[10] = '{4'd7,  3'd7, 1'b1};
        vecs[11] = '{4'd0,  3'd4, 1'b1};
        vecs[12] = '{4'd0,  3'd0, 1'b0};
        vecs[13] = '{4'd0,  3'd7, 1'b0};

        reset         = 1'b1;
        ser_clk_in    = 1'b0;
        ser_data_in   = 1'b0;
        ser_load_n_in = 1'b1;
        frame_sync_in = 1'b0;
        rd_col_in     = '0;
        rd_row_in     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        check_bit("reset pending", frame_pending_out, 1'b0);
        check_bit("reset err", frame_err_out, 1'b0);
        sweep("reset", 128'd0);

        // Single first bit -> col 15 row 7 after the swap only.
        start_load();
        send_bits(frame_a, 128);
        end_load();
        check_bit("A pending", frame_pending_out, 1'b1);
        check_bit("A err", frame_err_out, 1'b0);
        rd_check("A pre-sync", 15, 7, 1'b0);
        pulse_sync();
        check_bit("A pending after sync", frame_pending_out, 1'b0);
        sweep("A", frame_a);

        // Short load.
        start_load();
        send_bits(frame_b, 127);
        end_load();
        check_bit("short err", frame_err_out, 1'b1);
        check_bit("short pending", frame_pending_out, 1'b0);
        rd_check("short keeps A", 15, 7, 1'b1);

        // Valid load clears the error at the window open.
        start_load();
        check_bit("err clear on load", frame_err_out, 1'b0);
        send_bits(frame_b, 128);
        end_load();
        check_bit("B pending", frame_pending_out, 1'b1);
        pulse_sync();
        for (int i = 0; i < 14; i++) begin
            rd_check("B table", int'(vecs[i].col), int'(vecs[i].row), vecs[i].exp);
        end

        // Overrun load.
        start_load();
        send_bits(frame_c, 130);
        end_load();
        check_bit("overrun err", frame_err_out, 1'b1);
        check_bit("overrun pending", frame_pending_out, 1'b0);
        rd_check("overrun keeps B", 15, 0, 1'b1);

        // Full frame with no sync: display stays on B.
        start_load();
        send_bits(frame_c, 128);
        end_load();
        check_bit("C pending", frame_pending_out, 1'b1);
        check_bit("C err", frame_err_out, 1'b0);
        rd_check("C no sync keeps B", 15, 0, 1'b1);
        rd_check("C no sync keeps B", 0, 0, 1'b0);

        // New load while C pending discards C.
        start_load();
        check_bit("C discarded pending", frame_pending_out, 1'b0);
        pulse_sync();
        rd_check("C never shown", 0, 0, 1'b0);
        rd_check("C never shown", 15, 0, 1'b1);
        send_bits(frame_d, 128);
        end_load_aligned();
        check_bit("aligned pending", frame_pending_out, 1'b1);
        rd_check("aligned no swap", 0, 0, 1'b0);
        rd_check("aligned no swap", 15, 0, 1'b1);
        pulse_sync();
        check_bit("D pending after sync", frame_pending_out, 1'b0);
        sweep("D", frame_d);

        // Reset in the middle of a load.
        start_load();
        send_bits(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 60);
        @(negedge clk);
        reset         = 1'b1;
        ser_load_n_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_bit("mid reset pending", frame_pending_out, 1'b0);
        check_bit("mid reset err", frame_err_out, 1'b0);
        rd_check("mid reset cleared", 0, 0, 1'b0);
        rd_check("mid reset cleared", 15, 7, 1'b0);
        start_load();
        send_bits(frame_f, 128);
        end_load();
        check_bit("F pending", frame_pending_out, 1'b1);
        pulse_sync();
        sweep("F", frame_f);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream feeder for the LED panel scan driver: receives a 16-column x 8-row monochrome bitmap over a slow 3-wire serial link from the TinyTapeout input pins.
- Holds the bitmap in a shadow buffer and swaps it into the display buffer only at the driver's frame boundary, so the panel never shows a torn frame.
- The scan driver reads pixels through a combinational read port indexed by column and row.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchronizer (minimum 2).
- NCOLS, 16, bitmap columns (fixed; the column address is 4 bits).
- NROWS, 8, bitmap rows (fixed; the row address is 3 bits).

Ports:
- clk  input  1  system clock; all logic runs on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ser_clk_in  input  1  external serial clock; asynchronous to clk.
- ser_data_in  input  1  external serial data; sampled on ser_clk rising edges.
- ser_load_n_in  input  1  external frame-load window, active low; asynchronous.
- frame_sync_in  input  1  one-cycle pulse from the scan driver at its last-row wrap.
- rd_col_in  input  4  read column address.
- rd_row_in  input  3  read row address.
- rd_pixel_out  output  1  display_buf[rd_col_in][rd_row_in]; combinational.
- frame_pending_out  output  1  shadow holds a complete frame awaiting swap.
- frame_err_out  output  1  sticky error: the last load window ended with a bit count other than 128.

Behaviour:
- Reset, synchronous, highest priority:
  - display_buf and shadow_buf cleared to all zeros, so rd_pixel_out = 0 at every address.
  - bit_cnt = 0; state = IDLE; frame_pending_out = 0; frame_err_out = 0.
  - Synchronizer flops and edge-detect history are set to the idle levels: clk 0, load_n 1, data 0.
  - Reset asserted mid-load aborts the load; no partial data survives.
- Input synchronization and edge detection:
  - All three serial inputs pass through SYNC_STAGES flops.
  - Edges are detected against a further history flop.
  - A ser_clk rising edge is acted on SYNC_STAGES+1 clk cycles after the pin edge.
  - Data passes through an identical path and is sampled together with its edge.
  - External requirement: ser_clk high time and low time are each at least SYNC_STAGES+1 clk periods.
- State machine, IDLE -> SHIFT -> IDLE:
  - IDLE: a falling edge on synced load_n clears bit_cnt, clears frame_err_out and frame_pending_out, then enters SHIFT. A new load therefore discards any unswapped frame.
  - SHIFT, on each synced ser_clk rising edge:
    - If bit_cnt < 128: write the data bit to shadow_buf[15 - bit_cnt[6:3]][7 - bit_cnt[2:0]].
    - bit_cnt saturates at 128. It is 8 bits wide so that overrun is detectable.
    - Overrun bits (any edge arriving while bit_cnt = 128) are ignored for writing but set an internal overrun flag.
  - Resulting order: the first bit is col 15 row 7, the 8th bit is col 15 row 0, the 128th bit is col 0 row 0.
  - SHIFT, on a rising edge of synced load_n:
    - If bit_cnt == 128 and no overrun: frame_pending_out <= 1.
    - Otherwise: frame_err_out <= 1 and pending stays 0.
    - In both cases return to IDLE.
  - A ser_clk edge detected in the same cycle as the load_n rise is ignored.
- Swap:
  - In any cycle where frame_sync_in = 1 and frame_pending_out = 1: display_buf <= shadow_buf (all 128 bits, one cycle) and frame_pending_out <= 0.
  - If frame_pending_out is set in the same cycle as a frame_sync_in pulse, no swap occurs that cycle; the swap happens on the next frame_sync_in.
  - frame_sync_in while not pending: no effect.
  - frame_sync_in never touches shadow_buf or bit_cnt, so the swap and an ongoing load are independent.
- Read port:
  - Purely combinational from display_buf.
  - Reflects a swap on the cycle after the swap edge.

Test Plan:
- Reset, then sweep all 128 read addresses -> rd_pixel_out = 0 everywhere; pending = 0; err = 0.
- Load 128 bits with only bit 0 = 1, then pulse frame_sync -> pending = 1 after load_n rises, 0 after the sync; rd(15,7) = 1, all other addresses 0; display unchanged before the sync.
- Load 127 bits -> err = 1, pending = 0, display unchanged. Then load a valid frame -> err clears at the load_n fall.
- Load 130 bits -> err = 1, pending = 0. Separately, load a full frame with no frame_sync -> display keeps the old frame.
- Align the load_n rise so pending sets in the same cycle as a frame_sync pulse -> no swap then; swap on the next sync. Also start a second load while pending -> pending clears and the first frame is never displayed.
- Assert reset at bit 60 of a load, then do a full load plus sync -> the new frame displays correctly; no bits from the aborted load appear.
